// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types and helpers for the prefetching fetch stage.
package fetch_prefetch_unit_pkg;

  localparam int unsigned ADDR_W_DEF = 30;
  localparam int unsigned INST_W     = 32;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INST_W-1:0]     inst;
  } fetch_entry_t;

  // Little-endian memory word to instruction order.
  function automatic logic [INST_W-1:0] bswap32(input logic [INST_W-1:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_sync_fifo.sv
// Prefetch queue: DEPTH entries of {pc, inst}, flush wins over push/pop.
module fetch_prefetch_unit_sync_fifo
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               sync_rst,
  input  logic               i_push,
  input  fetch_entry_t       i_entry,
  input  logic               i_pop,
  input  logic               i_flush,
  output fetch_entry_t       o_head,
  output logic [CNT_W-1:0]   o_count
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (sync_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; emptiness is tracked by r_count.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush && !sync_rst) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage with credit-based prefetch queue between pipelined imem and decode.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W    = ADDR_W_DEF,
  parameter int unsigned        DEPTH     = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter bit                 BYTE_SWAP = 1'b1
) (
  input  logic              clk,
  input  logic              sync_rst,
  input  logic              clk_en,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_discard;

  logic              w_active;
  logic              w_credit;
  logic              w_req_fire;
  logic              w_rsp;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_nonempty;
  logic [CNT_W-1:0]  w_outstanding_nxt;
  logic [CNT_W-1:0]  w_fifo_count;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;

  // Every accepted request reserves a queue slot until it is popped.
  assign w_active   = clk_en & ~sync_rst;
  assign w_credit   = (SUM_W'(r_outstanding) + SUM_W'(w_fifo_count)) < SUM_W'(DEPTH);
  assign w_req_fire = imem_req_valid & imem_req_ready;
  assign w_rsp      = w_active & imem_rsp_valid;
  assign w_drop     = (r_discard != '0);
  assign w_push     = w_rsp & ~w_drop & ~jmp;
  assign w_flush    = w_active & jmp;
  assign w_nonempty = (w_fifo_count != '0);
  assign w_pop      = out_valid & out_ready & ~jmp;

  assign w_outstanding_nxt = r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp);

  assign imem_req_valid = w_active & ~jmp & w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign out_valid      = w_active & w_nonempty;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (clk_en) begin
      r_outstanding <= w_outstanding_nxt;
      if (jmp) begin
        // Everything still in flight belongs to the old stream.
        r_fetch_pc <= jmp_target;
        r_rsp_pc   <= jmp_target;
        r_discard  <= w_outstanding_nxt;
      end else begin
        if (w_req_fire)      r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
        if (w_push)          r_rsp_pc   <= r_rsp_pc + ADDR_W'(1);
        if (w_rsp && w_drop) r_discard  <= r_discard - CNT_W'(1);
      end
    end
  end

  assign w_push_entry.pc   = ADDR_W_DEF'(r_rsp_pc);
  assign w_push_entry.inst = imem_rsp_data;

  fetch_prefetch_unit_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .sync_rst (sync_rst),
    .i_push   (w_push),
    .i_entry  (w_push_entry),
    .i_pop    (w_pop),
    .i_flush  (w_flush),
    .o_head   (w_head),
    .o_count  (w_fifo_count)
  );

  assign out_pc   = w_nonempty ? ADDR_W'(w_head.pc) : '0;
  assign out_inst = w_nonempty ? (BYTE_SWAP ? bswap32(w_head.inst) : w_head.inst) : '0;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit with a pipelined in-order memory model.
`timescale 1ns/1ps
module tb_fetch_prefetch_unit;

  localparam int unsigned       ADDR_W   = 30;
  localparam int unsigned       DEPTH    = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  logic              clk = 1'b0;
  logic              sync_rst;
  logic              clk_en;
  logic              jmp;
  logic [ADDR_W-1:0] jmp_target;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_pc;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .RESET_PC  (RESET_PC),
    .BYTE_SWAP (1'b1)
  ) dut (
    .clk            (clk),
    .sync_rst       (sync_rst),
    .clk_en         (clk_en),
    .jmp            (jmp),
    .jmp_target     (jmp_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
    int                ep;
  } mem_req_t;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       inst;
  } exp_t;

  mem_req_t          mem_q[$];
  exp_t              exp_q[$];
  int                n_vec = 0;
  int                n_err = 0;
  int                cyc = 0;
  int                lat = 1;
  int                epoch = 0;
  int                n_out = 0;
  int                n_req = 0;
  int                first_out_cyc = -1;
  int                jmp_cyc = 0;
  int                fa_req_cyc = 0;
  logic [ADDR_W-1:0] exp_req_addr = '0;
  bit                last_req_valid = 1'b0;
  bit                arm_jmp = 1'b0;
  bit                jmp_hit = 1'b0;
  bit                post_rst = 1'b0;
  bit                seen_out = 1'b0;
  bit                seen_req = 1'b0;
  logic [ADDR_W-1:0] fa_pc = '1;
  logic [31:0]       fa_inst = '1;
  logic [ADDR_W-1:0] fa_req = '1;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(32'h200)) return 32'h1300_0000;
    return {a[15:0], ~a[15:0]} ^ 32'h0F1E_2D3C;
  endfunction

  function automatic logic [31:0] le_swap(input logic [31:0] d);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(3-b) +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sync_rst = 1'b1; clk_en = 1'b1; jmp = 1'b0; imem_rsp_valid = 1'b0;
      out_ready = 1'b1; imem_req_ready = 1'b1;
      #1;
      chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      if (i > 0) begin
        chk("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
        chk("rst_out_pc", 64'(out_pc), 64'(0));
        chk("rst_out_inst", 64'(out_inst), 64'(0));
      end
    end
    mem_q.delete();
    exp_q.delete();
    epoch++;
    exp_req_addr  = RESET_PC;
    cyc           = 0;
    post_rst      = 1'b1;
    first_out_cyc = -1;
    n_out         = 0;
    n_req         = 0;
    seen_out      = 1'b0;
    seen_req      = 1'b0;
  endtask

  // One clock: drive at negedge, sample 1ns later, then the DUT sees the posedge.
  task automatic run_cycle(input bit en, input bit j_req, input logic [ADDR_W-1:0] tgt,
                           input bit ordy, input bit qrdy);
    bit       rsp_now;
    bit       j;
    mem_req_t h;
    exp_t     e;
    @(negedge clk);
    rsp_now = en && (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    j = en && (j_req || (arm_jmp && rsp_now && out_valid && ordy));
    if (j && arm_jmp) begin
      arm_jmp = 1'b0;
      jmp_hit = 1'b1;
    end
    sync_rst = 1'b0; clk_en = en; jmp = j; jmp_target = tgt;
    out_ready = ordy; imem_req_ready = qrdy;
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
    #1;
    if (post_rst) begin
      chk("post_rst_out_valid", 64'(out_valid), 64'(0));
      chk("post_rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
      post_rst = 1'b0;
    end
    last_req_valid = imem_req_valid;
    if (!en) begin
      chk("hold_out_valid", 64'(out_valid), 64'(0));
      chk("hold_req_valid", 64'(imem_req_valid), 64'(0));
    end else begin
      if (out_valid && ordy && !j) begin
        chk("out_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_pc", 64'(out_pc), 64'(e.pc));
          chk("out_inst", 64'(out_inst), 64'(e.inst));
        end
        if (!seen_out) begin
          seen_out = 1'b1; fa_pc = out_pc; fa_inst = out_inst;
        end
        if (first_out_cyc < 0) first_out_cyc = cyc;
        n_out++;
      end
      if (imem_req_valid && qrdy) begin
        chk("req_addr", 64'(imem_req_addr), 64'(exp_req_addr));
        h.addr = imem_req_addr; h.due = cyc + lat; h.ep = epoch;
        mem_q.push_back(h);
        if (!seen_req) begin
          seen_req = 1'b1; fa_req = imem_req_addr; fa_req_cyc = cyc;
        end
        exp_req_addr++;
        n_req++;
      end
      if (rsp_now) begin
        h = mem_q.pop_front();
        if (h.ep == epoch && !j) begin
          e.pc = h.addr; e.inst = le_swap(mem_word(h.addr));
          exp_q.push_back(e);
        end
      end
      if (j) begin
        chk("jmp_req_valid", 64'(imem_req_valid), 64'(0));
        exp_q.delete();
        epoch++;
        exp_req_addr = tgt;
        seen_out = 1'b0;
        seen_req = 1'b0;
        jmp_cyc  = cyc;
      end
    end
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] t4_tgt;
    sync_rst = 1'b1; clk_en = 1'b0; jmp = 1'b0; jmp_target = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;

    // Zero-wait streaming.
    lat = 1;
    do_reset(2);
    repeat (40) run_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
    chk("t1_first_out_cyc", 64'(first_out_cyc), 64'(2));
    chk("t1_out_count", 64'(n_out), 64'(38));
    chk("t1_req_count", 64'(n_req), 64'(40));

    // Decode backpressure fills exactly DEPTH slots.
    do_reset(1);
    repeat (10) run_cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
    chk("t2_req_count", 64'(n_req), 64'(DEPTH));
    chk("t2_req_stalled", 64'(last_req_valid), 64'(0));
    repeat (20) run_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
    chk("t2_out_count", 64'(n_out), 64'(20));
    chk("t2_first_pc", 64'(fa_pc), 64'(0));

    // Latency 3, jump with three requests in flight.
    do_reset(1);
    lat = 3;
    repeat (12) run_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 10 && mem_q.size() != 3; k++) run_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
    chk("t3_outstanding", 64'(mem_q.size()), 64'(3));
    run_cycle(1'b1, 1'b1, ADDR_W'(32'h100), 1'b1, 1'b1);
    repeat (20) run_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
    chk("t3_first_pc", 64'(fa_pc), 64'(32'h100));
    chk("t3_first_inst", 64'(fa_inst), 64'(le_swap(mem_word(ADDR_W'(32'h100)))));

    // Jump coinciding with a response and a decode handshake.
    do_reset(1);
    lat = 2;
    t4_tgt = ADDR_W'(32'h0ABC_DE00);
    repeat (8) run_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
    arm_jmp = 1'b1; jmp_hit = 1'b0;
    for (int k = 0; k < 20 && !jmp_hit; k++) run_cycle(1'b1, 1'b0, t4_tgt, 1'b1, 1'b1);
    arm_jmp = 1'b0;
    chk("t4_jmp_hit", 64'(jmp_hit), 64'(1));
    repeat (15) run_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
    chk("t4_first_req", 64'(fa_req), 64'(t4_tgt));
    chk("t4_req_delay", 64'(fa_req_cyc - jmp_cyc), 64'(1));
    chk("t4_first_pc", 64'(fa_pc), 64'(t4_tgt));

    // Byte order, then a clock-enable hole mid-stream.
    lat = 1;
    run_cycle(1'b1, 1'b1, ADDR_W'(32'h200), 1'b1, 1'b1);
    repeat (6) run_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
    chk("t5_swap_pc", 64'(fa_pc), 64'(32'h200));
    chk("t5_swap_inst", 64'(fa_inst), 64'(32'h0000_0013));
    repeat (5) run_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    n_out = 0;
    repeat (10) run_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
    chk("t5_resume_outs", 64'(n_out), 64'(10));

    // Random ready, enable and jumps.
    lat = 2;
    for (int k = 0; k < 120; k++)
      run_cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
                ADDR_W'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));

    // Reset with a full queue.
    do_reset(1);
    lat = 1;
    repeat (10) run_cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
    chk("t6_full_stall", 64'(last_req_valid), 64'(0));
    do_reset(1);
    repeat (10) run_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
    chk("t6_first_pc", 64'(fa_pc), 64'(RESET_PC));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
